seq_detect_param: RTL and testbench

Parametrised serial sequence detector, the generalised successor to the fixed 6-bit group detector. Compares a 1-bit serial stream against a compile-time pattern with a per-bit don't-care mask. Two modes: grouped (non-overlapping SEQ_LEN-bit frames, verdict per frame) and sliding (overlapping, verdict every bit once the window is full). Sits directly on a serial data path; qualified by data_valid so it can tolerate gaps.

---
 rtl/seq_detect_param.sv | 79 +++++++
 tb/tb_seq_detect_param.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: serial pattern detector with per-bit don't-care mask, grouped or sliding windows.
// Optional saturating match counter enabled by defining SEQ_DET_CNT_EN.
module seq_detect_param #(
    parameter int                 SEQ_LEN = 6,
    parameter logic [SEQ_LEN-1:0] PATTERN = 6'b011100,
    parameter logic [SEQ_LEN-1:0] MASK    = 6'b111111,
    parameter int                 MODE    = 0,
    parameter int                 CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sync_clr,
    input  logic             data_valid,
    input  logic             data,
    output logic             match,
    output logic             not_match
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);
    localparam int CW = $clog2(SEQ_LEN);

    generate
        if (SEQ_LEN < 2 || SEQ_LEN > 32 || CNT_W < 1) begin : g_param_check
            $fatal(1, "seq_detect_param: SEQ_LEN must be 2..32 and CNT_W positive");
        end
    endgenerate

    logic [SEQ_LEN-2:0] sr;
    logic [CW-1:0]      cnt;
    logic [SEQ_LEN-1:0] w;
    logic               last;
    logic               hit;
    logic               eval;

    // window, evaluation and the qualifying condition for a verdict this cycle
    always_comb begin
        w    = {sr, data};
        last = cnt == CW'(SEQ_LEN - 1);
        hit  = ((w ^ PATTERN) & MASK) == '0;
        eval = data_valid && !sync_clr && last;
    end

    // shift register, bit counter (wraps in grouped mode, saturates in sliding) and verdict pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            cnt       <= '0;
            match     <= 1'b0;
            not_match <= 1'b0;
        end else if (sync_clr) begin
            sr        <= '0;
            cnt       <= '0;
            match     <= 1'b0;
            not_match <= 1'b0;
        end else begin
            match     <= eval && hit;
            not_match <= eval && !hit;
            if (data_valid) begin
                sr  <= w[SEQ_LEN-2:0];
                cnt <= last ? (MODE != 0 ? cnt : '0) : cnt + CW'(1);
            end
        end
    end

`ifdef SEQ_DET_CNT_EN
    // saturating count of match pulses, bumped on the same edge that raises match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            match_cnt <= '0;
        else if (sync_clr)
            match_cnt <= '0;
        else if (eval && hit && !(&match_cnt))
            match_cnt <= match_cnt + CNT_W'(1);
    end
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// tb_seq_detect_param: directed plus randomized check of three detector configurations against a history-based model.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sync_clr = 1'b0;
    logic data_valid = 1'b0;
    logic data = 1'b0;
    logic m0, n0, m1, n1, m2, n2;
`ifdef SEQ_DET_CNT_EN
    logic [1:0] c0;
    logic [7:0] c1, c2;
`endif

    int checks = 0;
    int passes = 0;
    int fails = 0;
    int mc = 0;
    bit hist[$];

    always #5 clk = ~clk;

    // u0: defaults, 2-bit counter for saturation
    seq_detect_param #(.CNT_W(2)) u0 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .data_valid(data_valid), .data(data),
        .match(m0), .not_match(n0)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(c0)
`endif
    );

    // u1: sliding 4-bit 1010
    seq_detect_param #(.SEQ_LEN(4), .PATTERN(4'b1010), .MASK(4'b1111), .MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .data_valid(data_valid), .data(data),
        .match(m1), .not_match(n1)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(c1)
`endif
    );

    // u2: grouped with two low bits don't-care
    seq_detect_param #(.MASK(6'b111100)) u2 (
        .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .data_valid(data_valid), .data(data),
        .match(m2), .not_match(n2)
`ifdef SEQ_DET_CNT_EN
        , .match_cnt(c2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // verdict from the list of valid bits seen since the last clear
    function automatic void model(input int len, input logic [31:0] pat, input logic [31:0] msk,
                                  input bit sliding, input bit fresh, output logic em, output logic en);
        int n = hist.size();
        logic [31:0] w = '0;
        bit ev = fresh && (sliding ? n >= len : (n > 0 && n % len == 0));
        if (ev)
            for (int i = 0; i < len; i++) w = {w[30:0], 1'(hist[n - len + i])};
        em = ev && (((w ^ pat) & msk) == 0);
        en = ev && !em;
    endfunction

    task automatic step(input logic v, input logic d, input logic c);
        logic e0, f0, e1, f1, e2, f2;
        data_valid = v;
        data = d;
        sync_clr = c;
        @(posedge clk);
        if (c) begin
            hist.delete();
            mc = 0;
        end else if (v) hist.push_back(d);
        model(6, 32'b011100, 32'b111111, 0, v && !c, e0, f0);
        model(4, 32'b1010, 32'b1111, 1, v && !c, e1, f1);
        model(6, 32'b011100, 32'b111100, 0, v && !c, e2, f2);
        if (e0) mc = (mc == 3) ? 3 : mc + 1;
        #1;
        chk("u0.match", 32'(m0), 32'(e0));
        chk("u0.not_match", 32'(n0), 32'(f0));
        chk("u1.match", 32'(m1), 32'(e1));
        chk("u1.not_match", 32'(n1), 32'(f1));
        chk("u2.match", 32'(m2), 32'(e2));
        chk("u2.not_match", 32'(n2), 32'(f2));
`ifdef SEQ_DET_CNT_EN
        chk("u0.match_cnt", 32'(c0), 32'(mc));
`endif
    endtask

    task automatic check_idle(input string tag);
        chk({tag, ".u0"}, {30'd0, m0, n0}, 32'd0);
        chk({tag, ".u1"}, {30'd0, m1, n1}, 32'd0);
        chk({tag, ".u2"}, {30'd0, m2, n2}, 32'd0);
`ifdef SEQ_DET_CNT_EN
        chk({tag, ".cnt"}, 32'(c0), 32'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        data_valid = 1'($urandom);
        data = 1'($urandom);
        #1;
        check_idle("reset_async");
        @(posedge clk);
        #1;
        check_idle("reset_hold");
        hist.delete();
        mc = 0;
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [31:0] bits, input int n, input bit gaps);
        for (int i = n - 1; i >= 0; i--) begin
            if (gaps && $urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), 1'b0);
            step(1'b1, bits[i], 1'b0);
        end
    endtask

    initial begin
        #2;
        do_reset();
        send(32'b011100_011100, 12, 0);
        send(32'b011100_111000, 12, 0);
        step(1'b0, 1'b0, 1'b1);
        send(32'b1010101, 7, 0);
        step(1'b1, 1'b1, 1'b1);
        send(32'b011, 3, 0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        send(32'b100, 3, 0);
        send(32'b011111_111100, 12, 0);
        send(32'b011, 3, 0);
        do_reset();
        send(32'b011100, 6, 0);
        send(32'b011, 3, 0);
        step(1'b1, 1'b0, 1'b1);
        repeat (5) send(32'b011100, 6, 1);
        step(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: send(32'b011100, 6, 1);
                3:       send(32'b1010, 4, 1);
                4:       step(1'($urandom), 1'($urandom), 1'b1);
                5:       if ($urandom_range(0, 3) == 0) do_reset(); else step(1'b0, 1'($urandom), 1'b0);
                default: repeat (6) step($urandom_range(0, 3) != 0, 1'($urandom), 1'b0);
            endcase
        end
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
